// File: rtl/tanh_sigmoid_pwl_pipe.sv
// Three-stage piecewise-linear tanh/sigmoid activation with valid/ready flow control
// and a saturating count of clip-segment results.
module tanh_sigmoid_pwl_pipe #(
  parameter int W     = 8,
  parameter int FRAC  = 5,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  in_data,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [W-1:0]  out_data,
  output logic                 out_sat,
  output logic [CNT_W-1:0]     sat_count
);

  localparam logic [W-1:0] ONE     = {{(W-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic [W-1:0] HALF    = ONE >> 1;
  localparam logic [W-1:0] QTR     = ONE >> 2;
  localparam logic [W-1:0] TWO     = ONE << 1;
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic         v1_q, v1_d, s1_q, s1_d, m1_q, m1_d;
  logic [W-1:0] a1_q, a1_d;
  logic         v2_q, v2_d, s2_q, s2_d, m2_q, m2_d, sat2_q, sat2_d;
  logic [W-1:0] mag2_q, mag2_d;
  logic         v3_q, v3_d, sat3_q, sat3_d;
  logic signed [W-1:0] y3_q, y3_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                stall;
  logic signed [W-1:0] z_c, t_c, sum_c;
  logic [W-1:0]        a_c;

  assign stall     = v3_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v3_q;
  assign out_data  = y3_q;
  assign out_sat   = sat3_q;
  assign sat_count = cnt_q;

  always_comb begin
    z_c = in_mode ? (in_data >>> 1) : in_data;
    a_c = z_c;
    // The most negative code has no positive twin; clamp it to the largest magnitude.
    if (z_c[W-1]) a_c = (z_c == MIN_NEG) ? MAX_POS : -z_c;
    t_c   = s2_q ? -$signed(mag2_q) : $signed(mag2_q);
    sum_c = t_c + $signed(ONE);
  end

  always_comb begin
    v1_d = v1_q;  s1_d = s1_q;  m1_d = m1_q;  a1_d = a1_q;
    v2_d = v2_q;  s2_d = s2_q;  m2_d = m2_q;  sat2_d = sat2_q;  mag2_d = mag2_q;
    v3_d = v3_q;  sat3_d = sat3_q;  y3_d = y3_q;
    if (!stall) begin
      v1_d = in_valid;
      s1_d = z_c[W-1];
      m1_d = in_mode;
      a1_d = a_c;

      v2_d   = v1_q;
      s2_d   = s1_q;
      m2_d   = m1_q;
      sat2_d = 1'b0;
      if (a1_q < HALF)      mag2_d = a1_q;
      else if (a1_q < ONE)  mag2_d = (a1_q >> 1) + QTR;
      else if (a1_q < TWO)  mag2_d = (a1_q >> 2) + HALF;
      else begin
        mag2_d = ONE - W'(1);
        sat2_d = 1'b1;
      end

      v3_d   = v2_q;
      sat3_d = sat2_q;
      y3_d   = m2_q ? (sum_c >>> 1) : t_c;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (v3_q && out_ready && sat3_q && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0;  s1_q <= 1'b0;  m1_q <= 1'b0;  a1_q <= '0;
      v2_q <= 1'b0;  s2_q <= 1'b0;  m2_q <= 1'b0;  sat2_q <= 1'b0;  mag2_q <= '0;
      v3_q <= 1'b0;  sat3_q <= 1'b0;  y3_q <= '0;
      cnt_q <= '0;
    end else begin
      v1_q <= v1_d;  s1_q <= s1_d;  m1_q <= m1_d;  a1_q <= a1_d;
      v2_q <= v2_d;  s2_q <= s2_d;  m2_q <= m2_d;  sat2_q <= sat2_d;  mag2_q <= mag2_d;
      v3_q <= v3_d;  sat3_q <= sat3_d;  y3_q <= y3_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
